// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: stallable, flushable control-word pipeline (Clk, Clr, Stall, Flush, Valid_in, Ctrl_in -> Ctrl_out, Valid_out, Occupancy, Stall_drop)
module ctrl_pipe_reg #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       Clk,
  input  logic                       Clr,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic                       Valid_in,
  input  logic [WIDTH-1:0]           Ctrl_in,
  output logic [WIDTH-1:0]           Ctrl_out,
  output logic                       Valid_out,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy,
  output logic                       Stall_drop
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, v_nx;
  logic [DEPTH:0] v_src;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] d_nx [DEPTH];
  logic [WIDTH-1:0] d_src [DEPTH+1];
  logic [OW-1:0] occ_nx;
  always_comb begin
    v_src = {v, Valid_in};
    d_src[0] = Ctrl_in;
    for (int k = 0; k < DEPTH; k++) d_src[k+1] = d[k];
    v_nx = v;
    d_nx = d;
    occ_nx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (Clr || Flush) begin
        v_nx[k] = 1'b0;
        d_nx[k] = NOP_VALUE;
      end else if (!Stall) begin
        v_nx[k] = v_src[k];
        d_nx[k] = v_src[k] ? d_src[k] : NOP_VALUE;
      end
      occ_nx = occ_nx + OW'(v_nx[k]);
    end
  end
  always_ff @(posedge Clk) begin
    v <= v_nx;
    d <= d_nx;
    Occupancy <= Clr ? '0 : occ_nx;
    Stall_drop <= Stall & Valid_in & ~Flush & ~Clr;
  end
  assign Ctrl_out = d[DEPTH-1];
  assign Valid_out = v[DEPTH-1];
endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb_ctrl_pipe_reg: scoreboard bench for ctrl_pipe_reg with WIDTH=8, DEPTH=3
module tb_ctrl_pipe_reg;
  logic clk = 1'b0;
  logic clr, stall, flush, valid_in, valid_out, stall_drop;
  logic [7:0] ctrl_in, ctrl_out;
  logic [1:0] occupancy;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  ctrl_pipe_reg #(.WIDTH(8), .DEPTH(3), .NOP_VALUE(8'h00)) dut (
    .Clk(clk), .Clr(clr), .Stall(stall), .Flush(flush), .Valid_in(valid_in),
    .Ctrl_in(ctrl_in), .Ctrl_out(ctrl_out), .Valid_out(valid_out),
    .Occupancy(occupancy), .Stall_drop(stall_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic vi, input logic st = 0,
                       input logic fl = 0, input logic cl = 0);
    ctrl_in = c; valid_in = vi; stall = st; flush = fl; clr = cl;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got %0h expected none", ctrl_out);
      end else chk("out_word", ctrl_out, exp_q.pop_front());
    end else chk("out_nop", ctrl_out, 8'h00);
  end

  initial begin
    drive(8'h00, 0, 0, 0, 1);
    drive(8'h00, 0, 0, 0, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_ctrl", ctrl_out, 8'h00);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", stall_drop, 0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    drive(8'hA1, 1); chk("fill_occ1", occupancy, 1);
    drive(8'hA2, 1); chk("fill_occ2", occupancy, 2);
    drive(8'hA3, 1); chk("fill_occ3", occupancy, 3);
    chk("lat_valid", valid_out, 1);
    chk("lat_ctrl", ctrl_out, 8'hA1);
    drive(8'hFF, 0); chk("drain_occ2", occupancy, 2);
    drive(8'h00, 0); chk("drain_occ1", occupancy, 1);
    drive(8'h00, 0); chk("drain_occ0", occupancy, 0);
    chk("bubble_valid", valid_out, 0);
    chk("bubble_ctrl", ctrl_out, 8'h00);
    drive(8'h00, 0); chk("drain_hold0", occupancy, 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    drive(8'h11, 1);
    drive(8'h22, 1);
    for (int i = 0; i < 4; i++) begin
      drive(8'h33, 1, 1);
      chk("stall_drop", stall_drop, 1);
      chk("stall_occ", occupancy, 2);
      chk("stall_valid", valid_out, 0);
    end
    drive(8'h00, 0); chk("stall_drop_end", stall_drop, 0);
    chk("unstall_ctrl", ctrl_out, 8'h11);
    drive(8'h00, 0); chk("unstall_ctrl2", ctrl_out, 8'h22);
    drive(8'h00, 0); chk("unstall_empty", occupancy, 0);
    exp_q.push_back(8'hB1);
    drive(8'hB1, 1); drive(8'hB2, 1); drive(8'hB3, 1);
    chk("full_occ", occupancy, 3);
    drive(8'hB4, 1, 1, 1);
    chk("flush_valid", valid_out, 0);
    chk("flush_ctrl", ctrl_out, 8'h00);
    chk("flush_occ", occupancy, 0);
    chk("flush_drop", stall_drop, 0);
    drive(8'h5A, 1); drive(8'h5B, 1);
    drive(8'h77, 1, 1, 0, 1);
    chk("clr_valid", valid_out, 0);
    chk("clr_ctrl", ctrl_out, 8'h00);
    chk("clr_occ", occupancy, 0);
    chk("clr_drop", stall_drop, 0);
    exp_q.push_back(8'h5C);
    drive(8'h5C, 1);
    drive(8'h00, 0);
    drive(8'h00, 0);
    chk("resume_valid", valid_out, 1);
    chk("resume_ctrl", ctrl_out, 8'h5C);
    drive(8'h00, 0);
    drive(8'h00, 0);
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_reg.md
CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 64: bit width of the control word carried per stage.
REQ-002 The module SHALL expose parameter DEPTH, default 2: number of register stages; legal range 1..8.
REQ-003 The module SHALL expose parameter NOP_VALUE, default {WIDTH{1'b0}}: control word presented by any invalid stage.
REQ-004 The module SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port Clr, input, 1 bit: reset; synchronous and active-high.
REQ-006 The module SHALL have port Stall, input, 1 bit: when high, all stages hold.
REQ-007 The module SHALL have port Flush, input, 1 bit: when high, all stages are invalidated.
REQ-008 The module SHALL have port Valid_in, input, 1 bit: Ctrl_in carries a real control word this cycle.
REQ-009 The module SHALL have port Ctrl_in, input, WIDTH bits: control word (enables, mux selects, opcode, state) entering stage 0.
REQ-010 The module SHALL have port Ctrl_out, output, WIDTH bits: control word of stage DEPTH-1.
REQ-011 The module SHALL have port Valid_out, output, 1 bit: valid flag of stage DEPTH-1.
REQ-012 The module SHALL have port Occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.
REQ-013 The module SHALL have port Stall_drop, output, 1 bit: pulses high when a valid Ctrl_in is discarded because Stall is high.

Function
REQ-014 Each stage k SHALL hold a valid bit V[k] and a data word D[k]; all outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-015 Advance (Stall=0, Flush=0, Clr=0): D[0] SHALL load Ctrl_in and V[0] SHALL load Valid_in; stage k>0 SHALL load stage k-1.
REQ-016 Bubble rule: a stage loading V=0 SHALL load NOP_VALUE into D, regardless of the incoming data word.
REQ-017 Latency SHALL be exactly DEPTH cycles from Ctrl_in/Valid_in sampling to Ctrl_out/Valid_out, when no stall occurs.
REQ-018 Stall=1 (Flush=0): every V[k] and D[k] SHALL hold; Ctrl_in SHALL be ignored.
REQ-019 Stall_drop SHALL be registered as Stall & Valid_in & ~Flush & ~Clr, so it is high in the cycle after the dropped input.
REQ-020 Flush=1: every V[k] SHALL clear to 0 and every D[k] SHALL load NOP_VALUE; Valid_in that cycle SHALL be discarded.
REQ-021 Priority SHALL be Clr > Flush > Stall > advance; when Flush and Stall are both high, the stages SHALL flush.
REQ-022 Occupancy SHALL equal the population count of the next-state V vector, registered so that it matches V after each edge; range 0..DEPTH, with no wrap.
REQ-023 When DEPTH=1, the stage SHALL be both input and output stage, and all rules above SHALL hold unchanged.

Reset
REQ-024 While Clr=1 at a rising edge, the next state SHALL be: all V[k]=0, all D[k]=NOP_VALUE, Valid_out=0, Ctrl_out=NOP_VALUE, Occupancy=0, Stall_drop=0.
REQ-025 Clr SHALL override Stall and Flush.
REQ-026 Clr asserted mid-stream SHALL discard all in-flight words, with no partial retention.
REQ-027 Normal advance SHALL resume on the first edge with Clr=0.

Verification (WIDTH=8, DEPTH=3, NOP_VALUE=8'h00)
REQ-028 Streaming: Valid_in=1 with Ctrl_in=8'hA1,8'hA2,8'hA3 on cycles 0-2 -> Ctrl_out=A1,A2,A3 and Valid_out=1 on cycles 3-5; Occupancy=3 at cycle 3.
REQ-029 Bubble: Valid_in=0 with Ctrl_in=8'hFF -> Ctrl_out=8'h00 and Valid_out=0 three cycles later; Occupancy does not count that stage.
REQ-030 Stall: load 8'h11,8'h22, then Stall=1 for 4 cycles with Valid_in=1 and Ctrl_in=8'h33 -> all stages hold; Stall_drop=1 for 4 cycles; 8'h33 never appears at Ctrl_out.
REQ-031 Flush+Stall: pipe full, Flush=1 and Stall=1 together -> next cycle Valid_out=0, Ctrl_out=8'h00, Occupancy=0.
REQ-032 Reset mid-operation: pipe holding 8'h5A, 8'h5B with Clr=1 for 1 cycle -> all outputs are at reset values next cycle; a new 8'h5C appears at Ctrl_out 3 cycles after Clr deasserts.
REQ-033 Occupancy boundaries: fill to 3 and drain with Valid_in=0 -> Occupancy steps 3,2,1,0 and holds 0, with no underflow.
